// File: rtl/noc_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module : noc_adapter_pkg
// Brief  : Shared widths, beat layout and beat-width helper for the NoC adapter.
// Rev    : 1.0  initial release
// ============================================================================
package noc_adapter_pkg;

    localparam int c_NOC_DW  = 512;
    localparam int c_BYTE_DW = 8;
    localparam int c_USER_DW = 32;

    // Beat layout at the default widths; the top mirrors this order per instance.
    typedef struct packed {
        logic [c_NOC_DW-1:0]           data;
        logic [c_NOC_DW/c_BYTE_DW-1:0] strb;
        logic [c_NOC_DW/c_BYTE_DW-1:0] keep;
        logic [c_BYTE_DW-1:0]          id;
        logic [c_BYTE_DW-1:0]          dest;
        logic [c_USER_DW-1:0]          user;
        logic                          last;
    } noc_beat_t;

    function automatic int beat_width(input int noc_dw, input int byte_dw, input int user_dw);
        return noc_dw + 2 * (noc_dw / byte_dw) + 2 * byte_dw + user_dw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_axis_fifo.sv
`default_nettype none
// ============================================================================
// Module : noc_axis_fifo
// Brief  : Synchronous FIFO with a registered head word and level-based flags.
// Rev    : 1.0  initial release
// ============================================================================
module noc_axis_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_LVL_W = c_PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [c_LVL_W-1:0] level
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [WIDTH-1:0]   r_head;
    logic               r_full;
    logic               r_empty;

    logic               w_push;
    logic               w_pop;
    logic [c_LVL_W-1:0] w_level_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [WIDTH-1:0]   w_head_nxt;

    always_comb begin
        w_push       = push & ~r_full;
        w_pop        = pop & ~r_empty;
        w_level_nxt  = r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
        w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);
        // The next head is the word being written only when it lands in an otherwise empty FIFO.
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = din;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
            r_full   <= 1'b1;   // reads full while in reset so no write is accepted
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_head   <= (w_level_nxt != '0) ? w_head_nxt : '0;
            r_full   <= (w_level_nxt == c_LVL_W'(DEPTH));
            r_empty  <= (w_level_nxt == '0);
        end
    end

    assign dout  = r_head;
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/noc_axis_buffered_adapter.sv
`default_nettype none
// ============================================================================
// Module : noc_axis_buffered_adapter
// Brief  : AXI-Stream beat buffer toward the NoC with dest override and counters.
// Rev    : 1.0  initial release
// ============================================================================
module noc_axis_buffered_adapter
    import noc_adapter_pkg::*;
#(
    parameter int NOC_DW        = c_NOC_DW,
    parameter int BYTE_DW       = c_BYTE_DW,
    parameter int USER_DW       = c_USER_DW,
    parameter int DEPTH         = 4,
    parameter int DEST_OVERRIDE = 0,
    parameter int CNT_W         = 32,
    localparam int c_STRB_W     = NOC_DW / BYTE_DW,
    localparam int c_LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                slave_tvalid,
    output logic                slave_tready,
    input  logic [NOC_DW-1:0]   slave_tdata,
    input  logic [c_STRB_W-1:0] slave_tstrb,
    input  logic [c_STRB_W-1:0] slave_tkeep,
    input  logic [BYTE_DW-1:0]  slave_tid,
    input  logic [BYTE_DW-1:0]  slave_tdest,
    input  logic [USER_DW-1:0]  slave_tuser,
    input  logic                slave_tlast,
    output logic                master_tvalid,
    input  logic                master_tready,
    output logic [NOC_DW-1:0]   master_tdata,
    output logic [c_STRB_W-1:0] master_tstrb,
    output logic [c_STRB_W-1:0] master_tkeep,
    output logic [BYTE_DW-1:0]  master_tid,
    output logic [BYTE_DW-1:0]  master_tdest,
    output logic [USER_DW-1:0]  master_tuser,
    output logic                master_tlast,
    input  logic [BYTE_DW-1:0]  dest_id,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    beat_count,
    output logic [c_LVL_W-1:0]  fifo_level
);

    localparam int c_BEAT_W = beat_width(NOC_DW, BYTE_DW, USER_DW);

    typedef struct packed {
        logic [NOC_DW-1:0]   data;
        logic [c_STRB_W-1:0] strb;
        logic [c_STRB_W-1:0] keep;
        logic [BYTE_DW-1:0]  id;
        logic [BYTE_DW-1:0]  dest;
        logic [USER_DW-1:0]  user;
        logic                last;
    } beat_t;

    beat_t               w_in_beat;
    beat_t               w_head;
    logic [c_BEAT_W-1:0] w_din;
    logic [c_BEAT_W-1:0] w_dout;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_send;
    logic [CNT_W-1:0]    r_pkt_count;
    logic [CNT_W-1:0]    r_beat_count;

    // The override destination is captured with the beat, so later dest_id changes leave buffered beats alone.
    always_comb begin
        w_in_beat.data = slave_tdata;
        w_in_beat.strb = slave_tstrb;
        w_in_beat.keep = slave_tkeep;
        w_in_beat.id   = slave_tid;
        w_in_beat.dest = (DEST_OVERRIDE != 0) ? dest_id : slave_tdest;
        w_in_beat.user = slave_tuser;
        w_in_beat.last = slave_tlast;
    end

    assign w_din    = w_in_beat;
    assign w_head   = beat_t'(w_dout);
    assign w_accept = slave_tvalid & ~w_full;
    assign w_send   = ~w_empty & master_tready;

    noc_axis_fifo #(
        .WIDTH (c_BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept),
        .din   (w_din),
        .pop   (w_send),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count <= '0;
            r_pkt_count  <= '0;
        end else if (w_send) begin
            r_beat_count <= r_beat_count + 1'b1;
            r_pkt_count  <= r_pkt_count + CNT_W'(w_head.last);
        end
    end

    assign slave_tready  = ~w_full;
    assign master_tvalid = ~w_empty;
    assign master_tdata  = w_head.data;
    assign master_tstrb  = w_head.strb;
    assign master_tkeep  = w_head.keep;
    assign master_tid    = w_head.id;
    assign master_tdest  = w_head.dest;
    assign master_tuser  = w_head.user;
    assign master_tlast  = w_head.last;
    assign pkt_count     = r_pkt_count;
    assign beat_count    = r_beat_count;

endmodule
`default_nettype wire

// File: tb/tb_noc_axis_buffered_adapter.sv
`default_nettype none
// ============================================================================
// Module : tb_noc_axis_buffered_adapter
// Brief  : Randomised bench with a queue model for the buffered NoC adapter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_noc_axis_buffered_adapter;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         slave_tvalid = 1'b0;
    logic [511:0] slave_tdata = '0;
    logic [63:0]  slave_tstrb = '0;
    logic [63:0]  slave_tkeep = '0;
    logic [7:0]   slave_tid = '0;
    logic [7:0]   slave_tdest = '0;
    logic [31:0]  slave_tuser = '0;
    logic         slave_tlast = 1'b0;
    logic         master_tready = 1'b0;
    logic [7:0]   dest_id = '0;

    logic         s_rdy, m_vld, m_last;
    logic [511:0] m_data;
    logic [63:0]  m_strb, m_keep;
    logic [7:0]   m_id, m_dest;
    logic [31:0]  m_user, pkt_cnt, beat_cnt;
    logic [2:0]   lvl;

    logic         o_s_rdy, o_m_vld, o_m_last;
    logic [511:0] o_m_data;
    logic [63:0]  o_m_strb, o_m_keep;
    logic [7:0]   o_m_id, o_m_dest;
    logic [31:0]  o_m_user, o_pkt_cnt, o_beat_cnt;
    logic [2:0]   o_lvl;

    always #5 clk = ~clk;

    noc_axis_buffered_adapter #(.DEPTH(DEPTH), .DEST_OVERRIDE(0)) dut (
        .clk(clk), .reset(reset),
        .slave_tvalid(slave_tvalid), .slave_tready(s_rdy), .slave_tdata(slave_tdata),
        .slave_tstrb(slave_tstrb), .slave_tkeep(slave_tkeep), .slave_tid(slave_tid),
        .slave_tdest(slave_tdest), .slave_tuser(slave_tuser), .slave_tlast(slave_tlast),
        .master_tvalid(m_vld), .master_tready(master_tready), .master_tdata(m_data),
        .master_tstrb(m_strb), .master_tkeep(m_keep), .master_tid(m_id),
        .master_tdest(m_dest), .master_tuser(m_user), .master_tlast(m_last),
        .dest_id(dest_id), .pkt_count(pkt_cnt), .beat_count(beat_cnt), .fifo_level(lvl)
    );

    noc_axis_buffered_adapter #(.DEPTH(DEPTH), .DEST_OVERRIDE(1)) dut_ov (
        .clk(clk), .reset(reset),
        .slave_tvalid(slave_tvalid), .slave_tready(o_s_rdy), .slave_tdata(slave_tdata),
        .slave_tstrb(slave_tstrb), .slave_tkeep(slave_tkeep), .slave_tid(slave_tid),
        .slave_tdest(slave_tdest), .slave_tuser(slave_tuser), .slave_tlast(slave_tlast),
        .master_tvalid(o_m_vld), .master_tready(master_tready), .master_tdata(o_m_data),
        .master_tstrb(o_m_strb), .master_tkeep(o_m_keep), .master_tid(o_m_id),
        .master_tdest(o_m_dest), .master_tuser(o_m_user), .master_tlast(o_m_last),
        .dest_id(dest_id), .pkt_count(o_pkt_cnt), .beat_count(o_beat_cnt), .fifo_level(o_lvl)
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  strb;
        logic [63:0]  keep;
        logic [7:0]   id;
        logic [7:0]   dest;
        logic [31:0]  user;
        logic         last;
    } beat_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain beat queue; ready is "fewer than DEPTH beats held", as seen after each edge.
    beat_t       q[$];
    logic [7:0]  qo[$];
    logic        e_rdy = 1'b0;
    logic        e_rst = 1'b0;
    bit   [31:0] e_beats = 0;
    bit   [31:0] e_pkts = 0;

    initial begin
        bit started = 0;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("slave_tready", s_rdy, e_rdy);
                chk("master_tvalid", m_vld, q.size() > 0);
                chk("fifo_level", lvl, q.size());
                chk("beat_count", beat_cnt, e_beats);
                chk("pkt_count", pkt_cnt, e_pkts);
                chk("ov_tvalid", o_m_vld, q.size() > 0);
                chk("ov_tready", o_s_rdy, e_rdy);
                if (q.size() > 0) begin
                    chk("tdata", m_data, q[0].data);
                    chk("tstrb", m_strb, q[0].strb);
                    chk("tkeep", m_keep, q[0].keep);
                    chk("tid", m_id, q[0].id);
                    chk("tdest", m_dest, q[0].dest);
                    chk("tuser", m_user, q[0].user);
                    chk("tlast", m_last, q[0].last);
                    chk("ov_tdest", o_m_dest, qo[0]);
                    chk("ov_tdata", o_m_data, q[0].data);
                end else if (e_rst) begin
                    chk("rst_tdata", m_data, 0);
                    chk("rst_tdest", m_dest, 0);
                    chk("rst_tlast", m_last, 0);
                end
            end
            started = 1;
            if (reset) begin
                q.delete();
                qo.delete();
                e_rdy   = 1'b0;
                e_beats = 0;
                e_pkts  = 0;
                e_rst   = 1'b1;
            end else begin
                bit acc;
                acc   = slave_tvalid && e_rdy;
                e_rst = 1'b0;
                if (q.size() > 0 && master_tready) begin
                    e_beats++;
                    if (q[0].last) e_pkts++;
                    void'(q.pop_front());
                    void'(qo.pop_front());
                end
                if (acc) begin
                    q.push_back('{slave_tdata, slave_tstrb, slave_tkeep, slave_tid,
                                  slave_tdest, slave_tuser, slave_tlast});
                    qo.push_back(dest_id);
                end
                e_rdy = (q.size() < DEPTH);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_beat(input logic last);
        for (int i = 0; i < 16; i++) slave_tdata[i*32 +: 32] = $urandom;
        slave_tstrb = {$urandom, $urandom};
        slave_tkeep = {$urandom, $urandom};
        slave_tid   = 8'($urandom);
        slave_tdest = 8'($urandom);
        slave_tuser = $urandom;
        slave_tlast = last;
    endtask

    initial begin
        // Reset then idle
        reset = 1'b1;
        step(3);
        chk("pin_rst_ready", s_rdy, 0);
        reset = 1'b0;
        step(1);
        chk("pin_ready_after_rst", s_rdy, 1);
        chk("pin_beats_zero", beat_cnt, 0);

        // Single beat
        rand_beat(1'b1);
        slave_tdata  = {64{8'hA5}};
        slave_tdest  = 8'd3;
        slave_tvalid = 1'b1;
        step(1);
        slave_tvalid  = 1'b0;
        chk("pin_single_valid", m_vld, 1);
        chk("pin_single_data", m_data, {64{8'hA5}});
        chk("pin_single_dest", m_dest, 3);
        master_tready = 1'b1;
        step(1);
        chk("pin_single_beats", beat_cnt, 1);
        chk("pin_single_pkts", pkt_cnt, 1);
        chk("pin_single_level", lvl, 0);

        // Fill and backpressure
        master_tready = 1'b0;
        slave_tvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_beat(i == 3);
            step(1);
        end
        chk("pin_full_level", lvl, 4);
        chk("pin_full_ready", s_rdy, 0);
        rand_beat(1'b1);
        step(1);
        chk("pin_held_level", lvl, 4);
        master_tready = 1'b1;
        step(1);
        chk("pin_ready_back", s_rdy, 1);
        step(1);
        slave_tvalid = 1'b0;
        step(6);

        // Streaming 20-beat packet with pointer wrap
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        slave_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_beat(i == 19);
            step(1);
        end
        slave_tvalid = 1'b0;
        step(2);
        chk("pin_stream_beats", beat_cnt, 20);
        chk("pin_stream_pkts", pkt_cnt, 1);

        // Destination override captured at acceptance
        master_tready = 1'b0;
        dest_id       = 8'd7;
        slave_tvalid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_beat(i == 2);
            slave_tdest = 8'd2;
            step(1);
        end
        slave_tvalid = 1'b0;
        dest_id      = 8'd9;
        step(1);
        chk("pin_ov_dest", o_m_dest, 7);
        chk("pin_plain_dest", m_dest, 2);
        master_tready = 1'b1;
        step(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            slave_tvalid  = ($urandom_range(0, 9) < 6);
            master_tready = ($urandom_range(0, 9) < 7);
            dest_id       = 8'($urandom);
            rand_beat($urandom_range(0, 3) == 0);
            step(1);
        end
        slave_tvalid  = 1'b0;
        master_tready = 1'b1;
        step(6);

        // Reset mid-packet
        master_tready = 1'b0;
        slave_tvalid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_beat(1'b0);
            step(1);
        end
        slave_tvalid = 1'b0;
        chk("pin_mid_level", lvl, 3);
        reset = 1'b1;
        step(1);
        chk("pin_mid_valid", m_vld, 0);
        chk("pin_mid_level0", lvl, 0);
        chk("pin_mid_beats", beat_cnt, 0);
        reset         = 1'b0;
        master_tready = 1'b1;
        step(5);
        chk("pin_no_stale", m_vld, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
